// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: operand forwarding, load-use stalls,
// taken-branch flushes, data-memory wait freezes and saturating hazard statistics.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned DELAY_SLOT  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_branch_taken,
    input  logic [4:0]       ex_rw,
    input  logic             ex_regwrite,
    input  logic             ex_load,
    input  logic [4:0]       mem_rw,
    input  logic [4:0]       wb_rw,
    input  logic             mem_regwrite,
    input  logic             wb_regwrite,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             pc_le,
    output logic             if_id_le,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] freeze_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout_err
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lu;
    logic              mw;
    logic              lu_stall;

    // Youngest producer wins; a load still in EX cannot forward and falls through.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] r,
        input logic       ex_we,
        input logic       ex_ld,
        input logic [4:0] ex_r,
        input logic       mem_we,
        input logic [4:0] mem_r,
        input logic       wb_we,
        input logic [4:0] wb_r
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (ex_we && !ex_ld && (ex_r != 5'd0) && (ex_r == r))
            sel = 2'd1;
        else if (mem_we && (mem_r != 5'd0) && (mem_r == r))
            sel = 2'd2;
        else if (wb_we && (wb_r != 5'd0) && (wb_r == r))
            sel = 2'd3;
        return sel;
    endfunction

    always_comb begin
        fwd_a_sel = fwd_sel(id_rs, ex_regwrite, ex_load, ex_rw,
                            mem_regwrite, mem_rw, wb_regwrite, wb_rw);
        fwd_b_sel = fwd_sel(id_rt, ex_regwrite, ex_load, ex_rw,
                            mem_regwrite, mem_rw, wb_regwrite, wb_rw);
    end

    assign lu = ex_load && ex_regwrite && (ex_rw != 5'd0) &&
                ((id_use_rs && (ex_rw == id_rs)) || (id_use_rt && (ex_rw == id_rt)));
    assign mw = mem_req && !mem_ready;
    assign lu_stall = lu && !mw;

    // Pipeline controls: memory wait over load-use over branch flush.
    always_comb begin
        pc_le        = 1'b1;
        if_id_le     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        freeze       = 1'b0;
        if (mw) begin
            freeze   = 1'b1;
            pc_le    = 1'b0;
            if_id_le = 1'b0;
        end else if (lu) begin
            pc_le        = 1'b0;
            if_id_le     = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (id_branch_taken && (DELAY_SLOT == 0)) begin
            if_id_flush = 1'b1;
        end
    end

    // Memory-wait tracker; the timeout flag is sticky but the wait continues.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= RUN;
            wait_cnt        <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mw) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (!mw) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        mem_timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Saturating hazard statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            freeze_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (lu_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (mw && (freeze_cnt != '1))
                freeze_cnt <= freeze_cnt + CNT_W'(1);
            if (if_id_flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
